// File: rtl/jk_cnt_pkg.sv
// Shared JK command encoding ({J,K}) for the JK-flip-flop based counters.
package jk_cnt_pkg;

  typedef logic [1:0] jk_cmd_t;

  localparam jk_cmd_t JK_HOLD = 2'b00;
  localparam jk_cmd_t JK_RST  = 2'b01;
  localparam jk_cmd_t JK_SET  = 2'b10;
  localparam jk_cmd_t JK_TGL  = 2'b11;

  // Command that forces a stage to the given value.
  function automatic jk_cmd_t jk_force(input logic value);
    return value ? JK_SET : JK_RST;
  endfunction

endpackage

// File: rtl/jk_stage.sv
// One posedge JK flip-flop with asynchronous active-high reset to 0.
module jk_stage (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  logic state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   state <= 1'b0;
        2'b10:   state <= 1'b1;
        2'b11:   state <= ~state;
        default: state <= state;
      endcase
    end
  end

  assign q     = state;
  assign q_bar = ~state;

endmodule

// File: rtl/jk_sync_up_counter.sv
// Synchronous modulo-MOD up counter built from JK stages, with tc/co/ovf.
// Optional parallel load (load, d) is present when UPCNT_LOAD_EN is defined.
module jk_sync_up_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MOD   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef UPCNT_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`endif
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             co,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  logic             do_load;
  logic [WIDTH-1:0] load_val;
  logic             wrap;
  logic [WIDTH-1:0] carry;

`ifdef UPCNT_LOAD_EN
  assign do_load  = load;
  assign load_val = d;
`else
  assign do_load  = 1'b0;
  assign load_val = '0;
`endif

  // ">=" rather than "==" so an out-of-range loaded value also wraps to 0.
  assign wrap = en & ~do_load & (q >= LAST);

  assign carry[0] = en;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
      assign carry[gi] = carry[gi-1] & q[gi-1];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
      jk_cmd_t cmd;

      always_comb begin
        if (do_load) begin
          cmd = jk_force(load_val[gi]);
        end else if (wrap) begin
          cmd = JK_RST;
        end else if (carry[gi]) begin
          cmd = JK_TGL;
        end else begin
          cmd = JK_HOLD;
        end
      end

      jk_stage u_stage (
        .clk   (clk),
        .rst   (rst),
        .j     (cmd[1]),
        .k     (cmd[0]),
        .q     (q[gi]),
        .q_bar (q_bar[gi])
      );
    end
  endgenerate

  // Set has priority over clear so a wrap is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (wrap) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  assign tc = (q == LAST);
  assign co = tc & en;

endmodule

// File: tb/tb_jk_sync_up_counter.sv
// Scoreboarded bench for jk_sync_up_counter (MOD=8, MOD=6 and a cascaded pair).
// Load scenarios run only when UPCNT_LOAD_EN is defined.
module tb_jk_sync_up_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en8 = 1'b0, clr8 = 1'b0;
  logic [2:0] q8, qb8;
  logic       tc8, co8, ovf8;
  logic       en6 = 1'b0, clr6 = 1'b0;
  logic [2:0] q6, qb6;
  logic       tc6, co6, ovf6;
`ifdef UPCNT_LOAD_EN
  logic       load8 = 1'b0, load6 = 1'b0;
  logic [2:0] d8 = '0, d6 = '0;
  logic       load_lo = 1'b0, load_hi = 1'b0;
  logic [2:0] d_lo = '0, d_hi = '0;
`endif
  logic       en_lo = 1'b0;
  logic [2:0] q_lo, qb_lo, q_hi, qb_hi;
  logic       tc_lo, co_lo, ovf_lo, tc_hi, co_hi, ovf_hi;

  jk_sync_up_counter #(.WIDTH(3), .MOD(8)) u_mod8 (
    .clk(clk), .rst(rst), .en(en8),
`ifdef UPCNT_LOAD_EN
    .load(load8), .d(d8),
`endif
    .clr_ovf(clr8), .q(q8), .q_bar(qb8), .tc(tc8), .co(co8), .ovf(ovf8)
  );

  jk_sync_up_counter #(.WIDTH(3), .MOD(6)) u_mod6 (
    .clk(clk), .rst(rst), .en(en6),
`ifdef UPCNT_LOAD_EN
    .load(load6), .d(d6),
`endif
    .clr_ovf(clr6), .q(q6), .q_bar(qb6), .tc(tc6), .co(co6), .ovf(ovf6)
  );

  jk_sync_up_counter #(.WIDTH(3), .MOD(8)) u_lo (
    .clk(clk), .rst(rst), .en(en_lo),
`ifdef UPCNT_LOAD_EN
    .load(load_lo), .d(d_lo),
`endif
    .clr_ovf(1'b0), .q(q_lo), .q_bar(qb_lo), .tc(tc_lo), .co(co_lo), .ovf(ovf_lo)
  );

  jk_sync_up_counter #(.WIDTH(3), .MOD(8)) u_hi (
    .clk(clk), .rst(rst), .en(co_lo),
`ifdef UPCNT_LOAD_EN
    .load(load_hi), .d(d_hi),
`endif
    .clr_ovf(1'b0), .q(q_hi), .q_bar(qb_hi), .tc(tc_hi), .co(co_hi), .ovf(ovf_hi)
  );

  int vectors = 0;
  int miscompares = 0;

  // Expected {q, q_bar, tc, co, ovf} plus which counter it belongs to.
  typedef struct {
    int         sel;
    logic [8:0] obs;
  } exp_t;
  exp_t sb[$];

  logic [2:0] m8_q = '0, m6_q = '0;
  logic       m8_ovf = 1'b0, m6_ovf = 1'b0;

  function automatic logic [8:0] observe(input int sel);
    if (sel == 0) return {q8, qb8, tc8, co8, ovf8};
    return {q6, qb6, tc6, co6, ovf6};
  endfunction

  // Drive one cycle of stimulus on counter sel (0: MOD=8, 1: MOD=6), the
  // other counter idles; predict the post-edge outputs and queue them.
  task automatic drive(input int sel, input logic e, input logic c,
                       input logic ld, input logic [2:0] dv);
    int         mod;
    logic [2:0] mq;
    logic       mo, wrapped, tc_e;
    exp_t       item;
    mod = (sel == 0) ? 8 : 6;
    mq  = (sel == 0) ? m8_q : m6_q;
    mo  = (sel == 0) ? m8_ovf : m6_ovf;
    @(negedge clk);
    en8 = (sel == 0) ? e : 1'b0;
    clr8 = (sel == 0) ? c : 1'b0;
    en6 = (sel == 1) ? e : 1'b0;
    clr6 = (sel == 1) ? c : 1'b0;
`ifdef UPCNT_LOAD_EN
    load8 = (sel == 0) ? ld : 1'b0;
    load6 = (sel == 1) ? ld : 1'b0;
    d8 = dv;
    d6 = dv;
`endif
    wrapped = !ld && e && (int'(mq) >= mod - 1);
    if (ld) mq = dv;
    else if (wrapped) mq = 3'd0;
    else if (e) mq = mq + 3'd1;
    if (wrapped) mo = 1'b1;
    else if (c) mo = 1'b0;
    tc_e = (int'(mq) == mod - 1);
    item.sel = sel;
    item.obs = {mq, ~mq, tc_e, tc_e & e, mo};
    sb.push_back(item);
    if (sel == 0) begin m8_q = mq; m8_ovf = mo; end
    else begin m6_q = mq; m6_ovf = mo; end
  endtask

  task automatic idle_all();
    @(negedge clk);
    en8 = 1'b0; clr8 = 1'b0; en6 = 1'b0; clr6 = 1'b0; en_lo = 1'b0;
`ifdef UPCNT_LOAD_EN
    load8 = 1'b0; load6 = 1'b0;
`endif
  endtask

  task automatic test_reset();
    logic [8:0] got;
    #3;
    got = observe(0);
    vectors++;
    if (got !== 9'b000_111_000) begin
      miscompares++;
      $display("FAIL reset_mod8: got %b want %b", got, 9'b000_111_000);
    end
    en8 = 1'b1;
    en6 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = observe(1);
    vectors++;
    if (got !== 9'b000_111_000) begin
      miscompares++;
      $display("FAIL reset_hold_mod6: got %b want %b", got, 9'b000_111_000);
    end
    @(negedge clk);
    en8 = 1'b0;
    en6 = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_count();
    exp_t e;
    logic [8:0] got;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1, 1'b0, 1'b0, 3'd0);
      @(posedge clk); #1;
      e = sb.pop_front();
      got = observe(e.sel);
      vectors++;
      if (got !== e.obs) begin
        miscompares++;
        $display("FAIL count step %0d: got %b want %b", i, got, e.obs);
      end
    end
    vectors++;
    if ({q8, ovf8} !== {3'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL count_final: got q=%0d ovf=%b want q=2 ovf=1", q8, ovf8);
    end
  endtask

  task automatic test_modulus();
    exp_t e;
    logic [8:0] got;
    for (int i = 0; i < 14; i++) begin
      drive(1, 1'b1, 1'b0, 1'b0, 3'd0);
      @(posedge clk); #1;
      e = sb.pop_front();
      got = observe(e.sel);
      vectors++;
      if (got !== e.obs || q6 > 3'd5) begin
        miscompares++;
        $display("FAIL modulus step %0d: got %b want %b", i, got, e.obs);
      end
    end
  endtask

  task automatic test_hold_clear();
    exp_t e;
    logic [8:0] got;
    // {en, clr_ovf}: reach 3, hold 5 cycles, clear, count to 7, wrap with clear.
    logic [1:0] stim [12] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                              2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 12; i++) begin
      drive(0, stim[i][1], stim[i][0], 1'b0, 3'd0);
      @(posedge clk); #1;
      e = sb.pop_front();
      got = observe(e.sel);
      vectors++;
      if (got !== e.obs) begin
        miscompares++;
        $display("FAIL hold_clear step %0d: got %b want %b", i, got, e.obs);
      end
    end
  endtask

`ifdef UPCNT_LOAD_EN
  task automatic test_load();
    exp_t e;
    logic [8:0] got;
    // {sel, en, clr, load, d}
    logic [6:0] stim [9] = '{
      {1'b0, 1'b0, 1'b1, 1'b0, 3'd0},
      {1'b0, 1'b0, 1'b0, 1'b1, 3'd5},
      {1'b0, 1'b1, 1'b0, 1'b0, 3'd0},
      {1'b0, 1'b1, 1'b0, 1'b0, 3'd0},
      {1'b0, 1'b1, 1'b0, 1'b1, 3'd2},
      {1'b1, 1'b0, 1'b1, 1'b0, 3'd0},
      {1'b1, 1'b0, 1'b0, 1'b1, 3'd7},
      {1'b1, 1'b0, 1'b0, 1'b0, 3'd0},
      {1'b1, 1'b1, 1'b0, 1'b0, 3'd0}};
    for (int i = 0; i < 9; i++) begin
      drive(int'(stim[i][6]), stim[i][5], stim[i][4], stim[i][3], stim[i][2:0]);
      @(posedge clk); #1;
      e = sb.pop_front();
      got = observe(e.sel);
      vectors++;
      if (got !== e.obs) begin
        miscompares++;
        $display("FAIL load step %0d: got %b want %b", i, got, e.obs);
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    exp_t e;
    logic [8:0] got;
    for (int i = 0; i < 8 && m8_q != 3'd4; i++) begin
      drive(0, 1'b1, 1'b0, 1'b0, 3'd0);
      @(posedge clk); #1;
      e = sb.pop_front();
      got = observe(e.sel);
      vectors++;
      if (got !== e.obs) begin
        miscompares++;
        $display("FAIL pre_reset step %0d: got %b want %b", i, got, e.obs);
      end
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({q8, qb8, ovf8} !== {3'd0, 3'b111, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got q=%b q_bar=%b ovf=%b want q=000 q_bar=111 ovf=0",
               q8, qb8, ovf8);
    end
    m8_q = '0; m8_ovf = 1'b0; m6_q = '0; m6_ovf = 1'b0;
    idle_all();
    rst = 1'b0;
  endtask

  task automatic test_cascade();
    @(negedge clk);
    en_lo = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    vectors++;
    if ({q_hi, q_lo} !== 6'd6) begin
      miscompares++;
      $display("FAIL cascade: got upper=%0d lower=%0d want upper=0 lower=6", q_hi, q_lo);
    end
    @(negedge clk);
    en_lo = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_modulus();
    test_hold_clear();
`ifdef UPCNT_LOAD_EN
    test_load();
`endif
    test_async_reset();
    test_cascade();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
